fetch_unit: RTL and testbench



---
 rtl/cpu_pkg.sv | 36 +++
 rtl/fetch_unit.sv | 121 ++++++++++++
 tb/tb_fetch_unit.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU constants, IR field layout and fetch FSM states
package cpu_pkg;

   localparam logic [3:0] OP_ADDI = 4'd8;
   localparam logic [3:0] OP_LI   = 4'd9;
   localparam logic [3:0] OP_ANDI = 4'd10;
   localparam logic [3:0] OP_JUMP = 4'd11;
   localparam logic [3:0] OP_BEZ  = 4'd12;
   localparam logic [3:0] OP_NOP  = 4'd15;

   localparam logic [1:0] PC_SRC_ALU_RESULT = 2'd0;
   localparam logic [1:0] PC_SRC_ALU_OUT    = 2'd1;
   localparam logic [1:0] PC_SRC_IMM        = 2'd2;
   localparam logic [1:0] PC_SRC_HOLD       = 2'd3;

   // Loaded into the IR when a fetch times out, so the control unit sees a harmless opcode.
   localparam logic [15:0] NOP_INSTR = {OP_NOP, 12'h000};

   localparam int OP_MSB  = 15;
   localparam int OP_LSB  = 12;
   localparam int RD_MSB  = 11;
   localparam int RD_LSB  = 8;
   localparam int RA_MSB  = 7;
   localparam int RA_LSB  = 4;
   localparam int RB_MSB  = 3;
   localparam int RB_LSB  = 0;
   localparam int IMM_MSB = 7;
   localparam int IMM_LSB = 0;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_DONE = 2'd2
   } fetch_state_t;

endpackage

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - PC/IR ownership, instruction fetch with wait states and timeout
module fetch_unit
   import cpu_pkg::*;
#(
   parameter int PC_W     = 8,
   parameter int INSTR_W  = 16,
   parameter int TIMEOUT  = 15,
   parameter int RESET_PC = 0
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               ir_load,
   input  logic               pc_write,
   input  logic               pc_write_cond,
   input  logic               zero,
   input  logic [1:0]         pc_src,
   input  logic [PC_W-1:0]    alu_result,
   input  logic [PC_W-1:0]    alu_out,
   output logic               mem_req,
   output logic [PC_W-1:0]    mem_addr,
   input  logic [INSTR_W-1:0] mem_rdata,
   input  logic               mem_ack,
   output logic [PC_W-1:0]    pc,
   output logic [3:0]         op_code,
   output logic [3:0]         rd,
   output logic [3:0]         ra,
   output logic [3:0]         rb,
   output logic [7:0]         imm,
   output logic               stall,
   output logic               mem_err
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);

   fetch_state_t        r_state;
   logic [CNT_W-1:0]    r_cnt;
   logic [INSTR_W-1:0]  r_ir;
   logic [PC_W-1:0]     r_pc;
   logic                r_mem_req;
   logic                r_mem_err;

   logic                w_pc_we;
   logic [PC_W-1:0]     w_pc_next;
   logic [PC_W-1:0]     w_imm_ext;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= ST_IDLE;
         r_cnt     <= '0;
         r_ir      <= '0;
         r_mem_req <= 1'b0;
         r_mem_err <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_cnt <= '0;
               if (ir_load) begin
                  r_state   <= ST_REQ;
                  r_mem_req <= 1'b1;
               end
            end
            ST_REQ: begin
               // An ack on the final allowed cycle beats the timeout.
               if (mem_ack) begin
                  r_ir      <= mem_rdata;
                  r_state   <= ST_DONE;
                  r_mem_req <= 1'b0;
               end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
                  r_ir      <= INSTR_W'(NOP_INSTR);
                  r_mem_err <= 1'b1;
                  r_state   <= ST_DONE;
                  r_mem_req <= 1'b0;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            ST_DONE: r_state <= ST_IDLE;
            default: begin
               r_state   <= ST_IDLE;
               r_mem_req <= 1'b0;
            end
         endcase
      end
   end

   // PC is frozen for the whole request so the memory address cannot move under it.
   assign w_pc_we   = (pc_write | (pc_write_cond & zero)) & (r_state != ST_REQ);
   assign w_imm_ext = PC_W'(r_ir[IMM_MSB:IMM_LSB]);

   always_comb begin
      w_pc_next = r_pc;
      case (pc_src)
         PC_SRC_ALU_RESULT: w_pc_next = alu_result;
         PC_SRC_ALU_OUT:    w_pc_next = alu_out;
         PC_SRC_IMM:        w_pc_next = w_imm_ext;
         PC_SRC_HOLD:       w_pc_next = r_pc;
         default:           w_pc_next = r_pc;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pc <= PC_W'(RESET_PC);
      end else if (w_pc_we) begin
         r_pc <= w_pc_next;
      end
   end

   assign mem_req  = r_mem_req;
   assign mem_addr = r_pc;
   assign pc       = r_pc;
   assign mem_err  = r_mem_err;
   assign stall    = ((r_state == ST_IDLE) & ir_load) | (r_state == ST_REQ);

   assign op_code = r_ir[OP_MSB:OP_LSB];
   assign rd      = r_ir[RD_MSB:RD_LSB];
   assign ra      = r_ir[RA_MSB:RA_LSB];
   assign rb      = r_ir[RB_MSB:RB_LSB];
   assign imm     = r_ir[IMM_MSB:IMM_LSB];

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        ir_load;
   logic        pc_write;
   logic        pc_write_cond;
   logic        zero;
   logic [1:0]  pc_src;
   logic [7:0]  alu_result;
   logic [7:0]  alu_out;
   logic        mem_req;
   logic [7:0]  mem_addr;
   logic [15:0] mem_rdata;
   logic        mem_ack;
   logic [7:0]  pc;
   logic [3:0]  op_code;
   logic [3:0]  rd;
   logic [3:0]  ra;
   logic [3:0]  rb;
   logic [7:0]  imm;
   logic        stall;
   logic        mem_err;

   int errors = 0;
   int checks = 0;

   fetch_unit #(
      .PC_W(8), .INSTR_W(16), .TIMEOUT(15), .RESET_PC(0)
   ) dut (
      .clk(clk), .rst(rst), .ir_load(ir_load), .pc_write(pc_write),
      .pc_write_cond(pc_write_cond), .zero(zero), .pc_src(pc_src),
      .alu_result(alu_result), .alu_out(alu_out), .mem_req(mem_req),
      .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
      .pc(pc), .op_code(op_code), .rd(rd), .ra(ra), .rb(rb), .imm(imm),
      .stall(stall), .mem_err(mem_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic nxt();
      @(negedge clk);
   endtask

   task automatic chk_ir(input string tag, input logic [15:0] ir);
      chk({tag, ".op"}, op_code, ir[15:12]);
      chk({tag, ".rd"}, rd, ir[11:8]);
      chk({tag, ".ra"}, ra, ir[7:4]);
      chk({tag, ".rb"}, rb, ir[3:0]);
      chk({tag, ".imm"}, imm, ir[7:0]);
   endtask

   // One fetch: ir_load cycle, waits+1 REQ cycles (ack on the last), then the DONE cycle.
   task automatic fetch(input string tag, input logic [15:0] data, input int waits,
                        input logic wr_in_req, input logic [7:0] exp_pc);
      nxt();
      ir_load = 1'b1;
      #1;
      chk({tag, ".stall_c0"}, stall, 1'b1);
      chk({tag, ".req_c0"}, mem_req, 1'b0);
      for (int i = 0; i <= waits; i++) begin
         nxt();
         ir_load    = 1'b0;
         mem_ack    = (i == waits);
         mem_rdata  = (i == waits) ? data : 16'hDEAD;
         pc_write   = wr_in_req;
         pc_src     = 2'd0;
         alu_result = 8'h77;
         #1;
         chk({tag, ".req"}, mem_req, 1'b1);
         chk({tag, ".stall_req"}, stall, 1'b1);
         chk({tag, ".addr"}, mem_addr, exp_pc);
      end
      nxt();
      mem_ack   = 1'b0;
      mem_rdata = 16'h0000;
      pc_write  = 1'b0;
      #1;
      chk({tag, ".stall_done"}, stall, 1'b0);
      chk({tag, ".req_done"}, mem_req, 1'b0);
      chk({tag, ".pc_done"}, pc, exp_pc);
      chk_ir(tag, data);
   endtask

   initial begin
      rst = 1'b1; ir_load = 1'b0; pc_write = 1'b0; pc_write_cond = 1'b0; zero = 1'b0;
      pc_src = 2'd0; alu_result = 8'h00; alu_out = 8'h00; mem_rdata = 16'h0000; mem_ack = 1'b0;

      nxt();
      #1;
      chk("rst.pc", pc, 8'h00);
      chk("rst.req", mem_req, 1'b0);
      chk("rst.err", mem_err, 1'b0);
      chk("rst.stall", stall, 1'b0);
      chk_ir("rst", 16'h0000);
      ir_load = 1'b1;
      #1;
      chk("rst.stall_follows", stall, 1'b1);
      ir_load = 1'b0;
      rst = 1'b0;

      fetch("zw", 16'h2A35, 0, 1'b0, 8'h00);
      chk("zw.err", mem_err, 1'b0);

      nxt();
      pc_write = 1'b1; pc_src = 2'd0; alu_result = 8'h05;
      nxt();
      pc_write = 1'b0;
      #1;
      chk("src0.pc", pc, 8'h05);
      chk("src0.addr", mem_addr, 8'h05);

      fetch("immf", 16'h12F0, 0, 1'b0, 8'h05);
      nxt();
      pc_write = 1'b1; pc_src = 2'd2;
      nxt();
      pc_write = 1'b0;
      #1;
      chk("src2.pc", pc, 8'hF0);

      pc_write_cond = 1'b1; zero = 1'b0; pc_src = 2'd1; alu_out = 8'h33;
      nxt();
      #1;
      chk("cond_z0.pc", pc, 8'hF0);
      zero = 1'b1;
      nxt();
      pc_write_cond = 1'b0; zero = 1'b0;
      #1;
      chk("cond_z1.pc", pc, 8'h33);

      pc_write = 1'b1; pc_src = 2'd3; alu_result = 8'h99; alu_out = 8'h99;
      nxt();
      pc_write = 1'b0;
      #1;
      chk("src3.pc", pc, 8'h33);

      fetch("wait3", 16'h5678, 3, 1'b1, 8'h33);
      nxt();
      #1;
      chk("wait3.pc_after", pc, 8'h33);

      ir_load = 1'b1;
      for (int i = 0; i < 15; i++) begin
         nxt();
         ir_load = 1'b0;
         #1;
         chk("to.req", mem_req, 1'b1);
         chk("to.err_pending", mem_err, 1'b0);
      end
      nxt();
      #1;
      chk("to.stall_done", stall, 1'b0);
      chk("to.req_done", mem_req, 1'b0);
      chk("to.err", mem_err, 1'b1);
      chk_ir("to", 16'hF000);

      fetch("after_to", 16'h3111, 0, 1'b0, 8'h33);
      chk("after_to.err_sticky", mem_err, 1'b1);

      rst = 1'b1;
      #1;
      chk("rst2.err", mem_err, 1'b0);
      chk("rst2.pc", pc, 8'h00);
      nxt();
      rst = 1'b0;
      fetch("ack_edge", 16'hC4D2, 14, 1'b0, 8'h00);
      chk("ack_edge.err", mem_err, 1'b0);

      nxt();
      pc_write = 1'b1; pc_src = 2'd0; alu_result = 8'h40;
      nxt();
      pc_write = 1'b0;
      #1;
      chk("pre_rst.pc", pc, 8'h40);
      ir_load = 1'b1;
      nxt();
      ir_load = 1'b0;
      #1;
      chk("midreq.req", mem_req, 1'b1);
      rst = 1'b1;
      #1;
      chk("midreq.req_drop", mem_req, 1'b0);
      chk("midreq.pc", pc, 8'h00);
      chk("midreq.stall", stall, 1'b0);
      nxt();
      rst = 1'b0; mem_ack = 1'b1; mem_rdata = 16'hBEEF;
      #1;
      chk("late_ack.req", mem_req, 1'b0);
      nxt();
      mem_ack = 1'b0;
      #1;
      chk_ir("late_ack", 16'h0000);
      chk("late_ack.req2", mem_req, 1'b0);
      chk("late_ack.stall", stall, 1'b0);
      chk("late_ack.pc", pc, 8'h00);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
